mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: ADDR_W, default 16, data-memory byte-address width; it SHALL match the width of mem_addr.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 mem_valid, mem_reg_we  in  1 each  instruction valid and register write enable, from the address/execute stage.
REQ-005 mem_drnum  in  5  destination register.
REQ-006 mem_addr  in  ADDR_W  effective byte address.
REQ-007 mem_alu_result  in  32  ALU result, or store data for stores.
REQ-008 mem_inst_op, mem_data_size, mem_extend_type  in  `INST_OP_WIDTH / `DATA_SIZE_WIDTH / `EXTEND_TYPE_WIDTH  decoded operation, access size and load extension.
REQ-009 dmem_req, dmem_we  out  1 each  memory request and write strobe.
REQ-010 dmem_addr  out  ADDR_W  word address, with bits [1:0] forced to 0.
REQ-011 dmem_wdata  out  32  lane-replicated store data.
REQ-012 dmem_be  out  4  byte enables.
REQ-013 dmem_ready, dmem_rdata  in  1 / 32  completion strobe; rdata is valid when ready=1.
REQ-014 mem_stall  out  1  upstream stages SHALL hold while this signal is 1.
REQ-015 wb_valid, wb_reg_we, wb_drnum, wb_data  out  1/1/5/32  registered writeback bundle.
REQ-016 mem_misaligned  out  1  one-cycle flag; present only when the macro in REQ-032 is defined.

Function
REQ-017 The FSM SHALL have two states: IDLE and WAIT.
REQ-018 Non-memory op, or mem_valid=0: dmem_req=0, and the wb bundle SHALL load the inputs on the next edge (latency 1); wb_data=mem_alu_result; wb_reg_we=mem_valid&&mem_reg_we.
REQ-019 LOAD/STORE with mem_valid=1 in IDLE: dmem_req=1 in the same cycle (combinational); the block SHALL capture addr, data, size, extend, drnum and reg_we into hold registers.
REQ-020 If dmem_ready=1 in that cycle, the access SHALL complete, wb SHALL update on the next edge, and the FSM SHALL stay in IDLE.
REQ-021 If dmem_ready=0, the FSM SHALL go to WAIT.
REQ-022 In WAIT: mem_stall=1, and dmem_req SHALL be driven from the hold registers, stable until dmem_ready. On dmem_ready=1 the FSM SHALL return to IDLE, wb SHALL update on the next edge, and mem_stall SHALL drop in the ready cycle.
REQ-023 In IDLE, mem_stall SHALL be 1 only when a memory op is valid and dmem_ready=0.
REQ-024 Whenever no access completes in a cycle, wb_valid SHALL be 0 on the next edge, with no duplicate writeback.
REQ-025 Store data and byte enables: byte: wdata={4{d[7:0]}}, be=1<<addr[1:0]; half: wdata={2{d[15:0]}}, be=addr[1]?4'b1100:4'b0011; word: wdata=d, be=4'b1111.
REQ-026 Load extraction: select the byte or half of rdata by addr[1:0], then sign- or zero-extend per extend_type.
REQ-027 Stores SHALL have dmem_we=1 and wb_reg_we=0.
REQ-028 Inputs arriving while in WAIT SHALL be ignored; upstream holds them.

Reset
REQ-029 On rst=1, asynchronously: FSM=IDLE; wb_valid=0, wb_reg_we=0, wb_drnum=0, wb_data=0; all hold registers=0; mem_misaligned=0.
REQ-030 While rst=1: dmem_req=0 and mem_stall=0.
REQ-031 Reset asserted in WAIT SHALL abandon the access; the first edge after deassertion SHALL treat the inputs as a new IDLE cycle.

Configuration
REQ-032 Macro MEM_STAGE_MISALIGN_CHECK_EN. When defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL suppress dmem_req, force wb_reg_we=0, and pulse mem_misaligned=1 for one cycle on the next edge.
REQ-033 When MEM_STAGE_MISALIGN_CHECK_EN is undefined: the mem_misaligned port SHALL be absent, and the low address bits SHALL be silently ignored by the alignment logic.

Verification
REQ-034 ALU op, drnum=5, result=0x1234, reg_we=1 -> next cycle wb_valid=1, wb_drnum=5, wb_data=0x1234; dmem_req never asserted.
REQ-035 LB at addr 0x0103 with dmem_rdata=0x80FF_FF00 and ready the same cycle -> dmem_addr=0x0100, wb_data=0xFFFF_FF80; with the unsigned extend -> 0x0000_0080.
REQ-036 SH at addr 0x0042, data 0xAAAA_BEEF -> dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1; wb_reg_we=0.
REQ-037 LW with ready held 0 for 3 cycles -> mem_stall=1 for 3 cycles, request signals constant throughout, exactly one wb_valid pulse after ready.
REQ-038 rst pulsed in the middle of WAIT -> dmem_req=0 immediately, FSM in IDLE, no wb_valid pulse.
REQ-039 With the macro defined, LW at 0x0006 -> no dmem_req, mem_misaligned=1 for 1 cycle, wb_reg_we=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with IDLE/WAIT handshake FSM and registered writeback.
// Optional MEM_STAGE_MISALIGN_CHECK_EN suppresses misaligned half/word accesses and flags them.
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 2
`endif
`ifndef DATA_SIZE_WIDTH
`define DATA_SIZE_WIDTH 2
`endif
`ifndef EXTEND_TYPE_WIDTH
`define EXTEND_TYPE_WIDTH 1
`endif
module mem_stage #(
    parameter int ADDR_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_valid,
    input  logic                          mem_reg_we,
    input  logic [4:0]                    mem_drnum,
    input  logic [ADDR_W-1:0]             mem_addr,
    input  logic [31:0]                   mem_alu_result,
    input  logic [`INST_OP_WIDTH-1:0]     mem_inst_op,
    input  logic [`DATA_SIZE_WIDTH-1:0]   mem_data_size,
    input  logic [`EXTEND_TYPE_WIDTH-1:0] mem_extend_type,
    output logic                          dmem_req,
    output logic                          dmem_we,
    output logic [ADDR_W-1:0]             dmem_addr,
    output logic [31:0]                   dmem_wdata,
    output logic [3:0]                    dmem_be,
    input  logic                          dmem_ready,
    input  logic [31:0]                   dmem_rdata,
    output logic                          mem_stall,
    output logic                          wb_valid,
    output logic                          wb_reg_we,
    output logic [4:0]                    wb_drnum,
    output logic [31:0]                   wb_data
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    ,output logic                         mem_misaligned
`endif
);
    localparam logic [`INST_OP_WIDTH-1:0]     OP_LOAD  = 1;
    localparam logic [`INST_OP_WIDTH-1:0]     OP_STORE = 2;
    localparam logic [`DATA_SIZE_WIDTH-1:0]   SZ_B     = 0;
    localparam logic [`DATA_SIZE_WIDTH-1:0]   SZ_H     = 1;
    localparam logic [`DATA_SIZE_WIDTH-1:0]   SZ_W     = 2;
    localparam logic [`EXTEND_TYPE_WIDTH-1:0] EXT_SIGN = 1;
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0]             h_addr, c_addr;
    logic [31:0]                   h_data, c_data, ld_data;
    logic [`INST_OP_WIDTH-1:0]     h_op, c_op;
    logic [`DATA_SIZE_WIDTH-1:0]   h_size, c_size;
    logic [`EXTEND_TYPE_WIDTH-1:0] h_ext, c_ext;
    logic [4:0]                    h_drnum, c_drnum;
    logic                          h_reg_we, c_reg_we;
    logic                          w, is_ls, mis, is_mem, acc, c_ld, sx;
    logic [7:0]                    rb;
    logic [15:0]                   rh;
    assign w     = state == WAIT;
    assign is_ls = mem_valid && (mem_inst_op == OP_LOAD || mem_inst_op == OP_STORE);
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    assign mis = is_ls && ((mem_data_size == SZ_H && mem_addr[0]) ||
                           (mem_data_size == SZ_W && mem_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif
    assign is_mem   = is_ls && !mis;
    assign acc      = w || is_mem;
    // While waiting, every request field comes from the hold registers so upstream changes are ignored.
    assign c_addr   = w ? h_addr   : mem_addr;
    assign c_data   = w ? h_data   : mem_alu_result;
    assign c_op     = w ? h_op     : mem_inst_op;
    assign c_size   = w ? h_size   : mem_data_size;
    assign c_ext    = w ? h_ext    : mem_extend_type;
    assign c_drnum  = w ? h_drnum  : mem_drnum;
    assign c_reg_we = w ? h_reg_we : mem_reg_we;
    assign c_ld     = c_op == OP_LOAD;
    always_comb begin
        state_n    = w ? (dmem_ready ? IDLE : WAIT) : (is_mem && !dmem_ready ? WAIT : IDLE);
        dmem_req   = !rst && acc;
        mem_stall  = dmem_req && !dmem_ready;
        dmem_we    = dmem_req && c_op == OP_STORE;
        dmem_addr  = {c_addr[ADDR_W-1:2], 2'b00};
        dmem_wdata = c_size == SZ_B ? {4{c_data[7:0]}} : c_size == SZ_H ? {2{c_data[15:0]}} : c_data;
        dmem_be    = c_size == SZ_B ? 4'b0001 << c_addr[1:0] :
                     c_size == SZ_H ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        rb         = 8'(dmem_rdata >> {c_addr[1:0], 3'b000});
        rh         = c_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        sx         = c_ext == EXT_SIGN;
        ld_data    = c_size == SZ_B ? {{24{sx && rb[7]}}, rb} :
                     c_size == SZ_H ? {{16{sx && rh[15]}}, rh} : dmem_rdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_addr   <= '0;
            h_data   <= '0;
            h_op     <= '0;
            h_size   <= '0;
            h_ext    <= '0;
            h_drnum  <= '0;
            h_reg_we <= 1'b0;
        end else if (!w && is_mem) begin
            h_addr   <= mem_addr;
            h_data   <= mem_alu_result;
            h_op     <= mem_inst_op;
            h_size   <= mem_data_size;
            h_ext    <= mem_extend_type;
            h_drnum  <= mem_drnum;
            h_reg_we <= mem_reg_we;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_reg_we      <= 1'b0;
            wb_drnum       <= '0;
            wb_data        <= '0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            mem_misaligned <= 1'b0;
`endif
        end else begin
            wb_valid       <= acc ? dmem_ready : mem_valid;
            wb_reg_we      <= acc ? dmem_ready && c_ld && c_reg_we : mem_valid && mem_reg_we && !mis;
            wb_drnum       <= c_drnum;
            wb_data        <= acc && c_ld ? ld_data : c_data;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            mem_misaligned <= mis;
`endif
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; writebacks are predicted at drive time and popped on wb_valid.
module tb_mem_stage;
    localparam logic [1:0] ALU = 0, LD = 1, ST = 2;
    localparam logic [1:0] B = 0, H = 1, W = 2;
    typedef struct {
        logic [4:0]  d;
        logic [31:0] data;
        logic        we;
        logic        chk;
    } sb_t;
    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_valid = 0, mem_reg_we = 0, dmem_ready = 0;
    logic [4:0]  mem_drnum = 0;
    logic [15:0] mem_addr = 0;
    logic [31:0] mem_alu_result = 0, dmem_rdata = 0;
    logic [1:0]  mem_inst_op = 0, mem_data_size = 0;
    logic        mem_extend_type = 0;
    logic        dmem_req, dmem_we, mem_stall, wb_valid, wb_reg_we;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_drnum;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    logic        mem_misaligned;
`endif
    int          checks = 0, failures = 0;
    sb_t         q[$];

    mem_stage #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_we(mem_reg_we),
        .mem_drnum(mem_drnum), .mem_addr(mem_addr), .mem_alu_result(mem_alu_result),
        .mem_inst_op(mem_inst_op), .mem_data_size(mem_data_size), .mem_extend_type(mem_extend_type),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_reg_we(wb_reg_we), .wb_drnum(wb_drnum), .wb_data(wb_data)
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        , .mem_misaligned(mem_misaligned)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_valid) begin
            sb_t e;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected drnum=%0d data=%h", wb_drnum, wb_data);
            end else begin
                e = q.pop_front();
                if (wb_drnum !== e.d || wb_reg_we !== e.we || (e.chk && wb_data !== e.data)) begin
                    failures++;
                    $display("FAIL wb_bundle got d=%0d we=%b data=%h exp d=%0d we=%b data=%h",
                             wb_drnum, wb_reg_we, wb_data, e.d, e.we, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ld_model(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [1:0] sz, input logic ext);
        logic [31:0] s;
        if (sz == B) begin
            s = rd >> (8 * a);
            return ext ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
        end
        if (sz == H) begin
            s = a[1] ? rd >> 16 : rd;
            return ext ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
        end
        return rd;
    endfunction

    task automatic drive(input logic v, input logic we, input logic [4:0] d, input logic [15:0] a,
                         input logic [31:0] x, input logic [1:0] op, input logic [1:0] sz,
                         input logic ext, input logic rdy, input logic [31:0] rd);
        @(posedge clk);
        #1;
        mem_valid = v; mem_reg_we = we; mem_drnum = d; mem_addr = a; mem_alu_result = x;
        mem_inst_op = op; mem_data_size = sz; mem_extend_type = ext; dmem_ready = rdy; dmem_rdata = rd;
        #1;
    endtask

    task automatic test_reset;
        mem_valid = 1; mem_inst_op = LD; mem_reg_we = 1; mem_drnum = 3;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
        checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
        checks++; if ({wb_valid, wb_reg_we, wb_drnum, wb_data} !== 39'h0) begin
            failures++; $display("FAIL reset_wb got=%b/%b/%0d/%h exp=0", wb_valid, wb_reg_we, wb_drnum, wb_data);
        end
        mem_valid = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_alu;
        drive(1, 1, 5, 16'h0040, 32'h1234, ALU, W, 0, 1, 32'hFFFF_FFFF);
        q.push_back('{5'd5, 32'h1234, 1'b1, 1'b1});
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL alu_req got=%b exp=0", dmem_req); end
        drive(0, 1, 6, 16'h0, 32'h5555, ALU, W, 0, 0, 0);
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", dmem_req); end
    endtask

    task automatic test_load;
        drive(1, 1, 7, 16'h0103, 32'h0, LD, B, 1, 1, 32'h80FF_FF00);
        q.push_back('{5'd7, 32'hFFFF_FF80, 1'b1, 1'b1});
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin failures++; $display("FAIL lb_req got=%b/%b exp=1/0", dmem_req, dmem_we); end
        checks++; if (dmem_addr !== 16'h0100) begin failures++; $display("FAIL lb_addr got=%h exp=0100", dmem_addr); end
        checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL lb_stall got=%b exp=0", mem_stall); end
        drive(1, 1, 8, 16'h0103, 32'h0, LD, B, 0, 1, 32'h80FF_FF00);
        q.push_back('{5'd8, 32'h0000_0080, 1'b1, 1'b1});
        drive(1, 1, 9, 16'h0202, 32'h0, LD, H, 1, 1, 32'h80FF_1234);
        q.push_back('{5'd9, 32'hFFFF_80FF, 1'b1, 1'b1});
        drive(1, 1, 10, 16'h0200, 32'h0, LD, W, 1, 1, 32'hCAFE_F00D);
        q.push_back('{5'd10, 32'hCAFE_F00D, 1'b1, 1'b1});
    endtask

    task automatic test_store;
        drive(1, 1, 11, 16'h0042, 32'hAAAA_BEEF, ST, H, 0, 1, 0);
        q.push_back('{5'd11, 32'h0, 1'b0, 1'b0});
        checks++; if (dmem_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", dmem_be); end
        checks++; if (dmem_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", dmem_wdata); end
        checks++; if (dmem_we !== 1'b1 || dmem_req !== 1'b1) begin failures++; $display("FAIL sh_we got=%b/%b exp=1/1", dmem_req, dmem_we); end
        drive(1, 0, 12, 16'h0041, 32'h1234_5678, ST, B, 0, 1, 0);
        q.push_back('{5'd12, 32'h0, 1'b0, 1'b0});
        checks++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h7878_7878) begin
            failures++; $display("FAIL sb_lane got be=%b wdata=%h exp be=0010 wdata=78787878", dmem_be, dmem_wdata);
        end
        drive(1, 0, 13, 16'h0048, 32'h0BAD_CAFE, ST, W, 0, 1, 0);
        q.push_back('{5'd13, 32'h0, 1'b0, 1'b0});
        checks++; if (dmem_be !== 4'b1111 || dmem_wdata !== 32'h0BAD_CAFE || dmem_addr !== 16'h0048) begin
            failures++; $display("FAIL sw_lane got be=%b wdata=%h addr=%h exp be=1111 wdata=0badcafe addr=0048", dmem_be, dmem_wdata, dmem_addr);
        end
    endtask

    task automatic test_wait;
        drive(1, 1, 14, 16'h0010, 32'h0, LD, W, 0, 0, 32'h1111_1111);
        checks++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin failures++; $display("FAIL wait_c1 got req=%b stall=%b exp=1/1", dmem_req, mem_stall); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 20, 16'h0777, 32'h9999, ALU, B, 1, 0, 32'h2222_2222);
            checks++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1 || dmem_addr !== 16'h0010 || dmem_we !== 1'b0 || dmem_be !== 4'b1111) begin
                failures++; $display("FAIL wait_hold got req=%b stall=%b addr=%h we=%b be=%b exp 1/1/0010/0/1111", dmem_req, mem_stall, dmem_addr, dmem_we, dmem_be);
            end
        end
        drive(1, 1, 20, 16'h0777, 32'h9999, ALU, B, 1, 1, 32'hDEAD_BEEF);
        q.push_back('{5'd14, 32'hDEAD_BEEF, 1'b1, 1'b1});
        checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin failures++; $display("FAIL wait_done got req=%b stall=%b exp=1/0", dmem_req, mem_stall); end
        drive(0, 0, 0, 16'h0, 32'h0, ALU, W, 0, 0, 0);
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL wait_exit got req=%b exp=0", dmem_req); end
    endtask

    task automatic test_reset_in_wait;
        drive(1, 1, 15, 16'h0020, 32'h0, LD, W, 0, 0, 0);
        drive(0, 0, 0, 16'h0, 32'h0, ALU, W, 0, 0, 0);
        checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL rw_inwait got stall=%b exp=1", mem_stall); end
        #1 rst = 1;
        #1;
        checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL rw_async got req=%b stall=%b exp=0/0", dmem_req, mem_stall); end
        @(posedge clk);
        #1 rst = 0;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rw_wb got=%b exp=0", wb_valid); end
        drive(1, 1, 16, 16'h0030, 32'h0000_0099, ALU, W, 0, 0, 0);
        q.push_back('{5'd16, 32'h0000_0099, 1'b1, 1'b1});
        checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin failures++; $display("FAIL rw_idle got req=%b stall=%b exp=0/0", dmem_req, mem_stall); end
        drive(1, 1, 17, 16'h0031, 32'h0, LD, B, 0, 1, 32'h0000_A500);
        q.push_back('{5'd17, 32'h0000_00A5, 1'b1, 1'b1});
        checks++; if (dmem_req !== 1'b1 || mem_stall !== 1'b0) begin failures++; $display("FAIL rw_newreq got req=%b stall=%b exp=1/0", dmem_req, mem_stall); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op, sz;
            logic [15:0] a;
            logic [31:0] rd, x;
            logic        ext, we;
            op  = $urandom_range(1) ? LD : ALU;
            sz  = 2'($urandom_range(2));
            a   = 16'($urandom);
            a   = sz == W ? a & 16'hFFFC : sz == H ? a & 16'hFFFE : a;
            rd  = $urandom;
            x   = $urandom;
            ext = 1'($urandom_range(1));
            we  = 1'($urandom_range(1));
            drive(1, we, 5'(i), a, x, op, sz, ext, 1, rd);
            q.push_back('{5'(i), op == LD ? ld_model(rd, a[1:0], sz, ext) : x, we, 1'b1});
            checks++; if (dmem_req !== (op == LD)) begin failures++; $display("FAIL b2b_req i=%0d got=%b exp=%b", i, dmem_req, op == LD); end
        end
        drive(0, 0, 0, 16'h0, 32'h0, ALU, W, 0, 0, 0);
    endtask

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    task automatic test_misaligned;
        drive(1, 1, 18, 16'h0006, 32'h0, LD, W, 0, 1, 32'h1234_5678);
        q.push_back('{5'd18, 32'h0, 1'b0, 1'b0});
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", dmem_req); end
        @(posedge clk);
        #1 mem_valid = 0;
        checks++; if (mem_misaligned !== 1'b1 || wb_reg_we !== 1'b0) begin failures++; $display("FAIL mis_flag got mis=%b we=%b exp=1/0", mem_misaligned, wb_reg_we); end
        @(posedge clk);
        #1;
        checks++; if (mem_misaligned !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", mem_misaligned); end
    endtask
`endif

    initial begin
        test_reset;
        test_alu;
        test_load;
        test_store;
        test_wait;
        test_reset_in_wait;
        test_back_to_back;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        test_misaligned;
`endif
        repeat (3) @(posedge clk);
        #6;
        checks++; if (q.size() != 0) begin failures++; $display("FAIL wb_missing got=%0d pending exp=0", q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
